// File: rtl/cu_pkg.sv
// Shared definitions for the cu_sequencer control unit: opcodes, state encoding,
// register-select codes and the datapath control word.
package cu_pkg;

    localparam int unsigned OP_NOP = 0;
    localparam int unsigned OP_LDA = 1;
    localparam int unsigned OP_LDB = 2;
    localparam int unsigned OP_ADD = 3;
    localparam int unsigned OP_STR = 4;
    localparam int unsigned OP_CLR = 5;
    localparam int unsigned OP_HLT = 15;

    typedef enum logic [2:0] {
        ST_RST_WAIT = 3'd0,
        ST_FETCH    = 3'd1,
        ST_INCPC    = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WB       = 3'd4,
        ST_HALT     = 3'd5
    } state_e;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_RES  = 2'b01;
    localparam logic [1:0] SEL_CLR  = 2'b10;
    localparam logic [1:0] SEL_BUS  = 2'b11;

    typedef struct packed {
        logic       hlt;
        logic       inc;
        logic       repc;
        logic       reir;
        logic       redmem;
        logic       rer;
        logic [1:0] cu_a;
        logic [1:0] cu_b;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{hlt: 1'b0, inc: 1'b0, repc: 1'b0, reir: 1'b0,
                                    redmem: 1'b0, rer: 1'b0,
                                    cu_a: SEL_HOLD, cu_b: SEL_HOLD};

    // Successor of EXEC: ADD needs a write-back cycle, halt and illegal opcodes park.
    function automatic state_e exec_next(input int unsigned op);
        case (op)
            OP_NOP, OP_LDA, OP_LDB, OP_STR, OP_CLR: exec_next = ST_FETCH;
            OP_ADD:                                 exec_next = ST_WB;
            default:                                exec_next = ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational control-word decode from (state, opcode).
module cu_decode
    import cu_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  state_e          state_i,
    input  logic [OP_W-1:0] ir_op_i,
    output ctrl_t           ctrl_o
);

    logic [31:0] op;
    assign op = 32'(ir_op_i);

    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            ST_FETCH: ctrl_o.reir = 1'b1;
            ST_INCPC: begin
                ctrl_o.inc  = 1'b1;
                ctrl_o.repc = 1'b1;
            end
            ST_EXEC: begin
                case (op)
                    OP_NOP: ;
                    OP_LDA: ctrl_o.cu_a = SEL_BUS;
                    OP_LDB: ctrl_o.cu_b = SEL_BUS;
                    OP_ADD: ctrl_o.rer = 1'b1;
                    OP_STR: ctrl_o.redmem = 1'b1;
                    OP_CLR: begin
                        ctrl_o.cu_a = SEL_CLR;
                        ctrl_o.cu_b = SEL_CLR;
                    end
                    default: ctrl_o.hlt = 1'b1;
                endcase
            end
            ST_WB:   ctrl_o.cu_a = SEL_RES;
            ST_HALT: ctrl_o.hlt  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// Control-unit FSM driving the no_control_full datapath.
// CU_SINGLE_STEP_EN adds a step input that gates each instruction fetch.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset_full_n,
`ifdef CU_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [OP_W-1:0] ir_op,
    output logic            HLT,
    output logic            INC,
    output logic            REPC,
    output logic            REIR,
    output logic            REDMEM,
    output logic            RER,
    output logic [1:0]      cu_A,
    output logic [1:0]      cu_B,
    output logic [2:0]      state_o
);

    state_e state_q, state_d;
    ctrl_t  dec_ctrl, ctrl;

`ifdef CU_SINGLE_STEP_EN
    // go_q arms the FETCH cycle that actually loads the IR after a step pulse.
    logic go_q, go_d;

    always_comb begin
        go_d = go_q;
        if (state_q == ST_FETCH) go_d = go_q ? 1'b0 : step;
    end

    always_ff @(posedge clk or negedge reset_full_n) begin
        if (!reset_full_n) go_q <= 1'b0;
        else               go_q <= go_d;
    end

    assign ctrl = (state_q == ST_FETCH && !go_q) ? CTRL_IDLE : dec_ctrl;
`else
    assign ctrl = dec_ctrl;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST_WAIT: state_d = ST_FETCH;
`ifdef CU_SINGLE_STEP_EN
            ST_FETCH:    state_d = go_q ? ST_INCPC : ST_FETCH;
`else
            ST_FETCH:    state_d = ST_INCPC;
`endif
            ST_INCPC:    state_d = ST_EXEC;
            ST_EXEC:     state_d = exec_next(32'(ir_op));
            ST_WB:       state_d = ST_FETCH;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_full_n) begin
        if (!reset_full_n) state_q <= ST_RST_WAIT;
        else               state_q <= state_d;
    end

    cu_decode #(.OP_W(OP_W)) u_decode (
        .state_i (state_q),
        .ir_op_i (ir_op),
        .ctrl_o  (dec_ctrl)
    );

    assign HLT     = ctrl.hlt;
    assign INC     = ctrl.inc;
    assign REPC    = ctrl.repc;
    assign REIR    = ctrl.reir;
    assign REDMEM  = ctrl.redmem;
    assign RER     = ctrl.rer;
    assign cu_A    = ctrl.cu_a;
    assign cu_B    = ctrl.cu_b;
    assign state_o = state_q;

endmodule
